// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the cache-block memory port arbiter and its burst sequencer.
// Holds the FSM encoding, burst length and requester identifiers.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_BURST = 2'd1,
        ST_WR_BURST = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    localparam int   BURST_LEN = 4;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

    function automatic logic [31:0] block_word(input logic [127:0] blk, input logic [1:0] idx);
        return blk[32*idx +: 32];
    endfunction

endpackage

// File: rtl/mem_port_arbiter_burst_sequencer.sv
// Burst engine: owns the beat counter, latched base/block and memory-side address/data.
// Latency: outputs follow registered state; a stalled beat (mem_ready=0) holds addr/we/wdata.
module burst_sequencer #(
    parameter int ADDR_BITS = 12,
    parameter int BURST_LEN = mem_port_arbiter_pkg::BURST_LEN
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 load,
    input  logic [ADDR_BITS-5:0] load_base,
    input  logic [127:0]         load_block,
    input  logic                 run,
    input  logic                 wr,
    input  logic                 mem_ready,
    output logic [1:0]           beat,
    output logic                 last_beat,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [3:0]           mem_we,
    output logic [31:0]          mem_wdata
);
    import mem_port_arbiter_pkg::*;

    localparam logic [1:0] LAST_BEAT = 2'(BURST_LEN - 1);

    logic [ADDR_BITS-5:0] base_q;
    logic [127:0]         block_q;

    assign last_beat = run && mem_ready && (beat == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (nrst) begin
            beat    <= '0;
            base_q  <= '0;
            block_q <= '0;
        end else if (load) begin
            beat    <= '0;
            base_q  <= load_base;
            block_q <= load_block;
        end else if (run && mem_ready) begin
            // the only wrap point is the final accepted beat, so beat never passes LAST_BEAT
            beat <= last_beat ? 2'd0 : beat + 2'd1;
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = '0;
        mem_wdata = '0;
        if (run) begin
            mem_addr = {base_q, beat, 2'b00};
            if (wr) begin
                mem_we    = 4'hF;
                mem_wdata = block_word(block_q, beat);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter between cache refill (read) and evict (write) block bursts to one memory port.
// Latency: pulse in cycle 0 -> beats in cycles 1-4, done pulse in cycle 5; mem_ready=0 stalls the beat.
module mem_port_arbiter #(
    parameter int ADDR_BITS = 12,
    parameter int BURST_LEN = mem_port_arbiter_pkg::BURST_LEN
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 i_rd_req,
    input  logic [ADDR_BITS-5:0] i_rd_base,
    output logic [31:0]          o_rd_data,
    output logic                 o_rd_valid,
    output logic [1:0]           o_rd_beat,
    output logic                 o_rd_done,
    input  logic                 i_wr_req,
    input  logic [ADDR_BITS-5:0] i_wr_base,
    input  logic [127:0]         i_wr_block,
    output logic                 o_wr_done,
    output logic [ADDR_BITS-1:0] o_mem_addr,
    output logic [3:0]           o_mem_we,
    output logic [31:0]          o_mem_wdata,
    input  logic [31:0]          i_mem_rdata,
    input  logic                 i_mem_ready,
    output logic                 o_busy
);
    import mem_port_arbiter_pkg::*;

    state_t               state;
    logic                 pend_rd, pend_wr;
    logic                 last_grant;
    logic [ADDR_BITS-5:0] rd_base_q, wr_base_q;
    logic [127:0]         wr_block_q;
    logic                 rd_valid_q;
    logic [1:0]           rd_beat_q;

    logic                 rd_take, wr_take, want_rd, want_wr;
    logic                 grant_wr, start;
    logic [ADDR_BITS-5:0] eff_rd_base, eff_wr_base, load_base;
    logic [127:0]         eff_wr_block;

    logic                 run, wr_run, last_beat;
    logic [1:0]           beat;
    logic [ADDR_BITS-1:0] seq_addr;
    logic [3:0]           seq_we;
    logic [31:0]          seq_wdata;

    // a pulse arriving while the same requester is already pending is dropped
    assign rd_take = i_rd_req && !pend_rd;
    assign wr_take = i_wr_req && !pend_wr;
    assign want_rd = pend_rd || i_rd_req;
    assign want_wr = pend_wr || i_wr_req;

    assign eff_rd_base  = pend_rd ? rd_base_q  : i_rd_base;
    assign eff_wr_base  = pend_wr ? wr_base_q  : i_wr_base;
    assign eff_wr_block = pend_wr ? wr_block_q : i_wr_block;

    assign grant_wr  = want_wr && (!want_rd || last_grant == REQ_READ);
    assign start     = (state == ST_IDLE) && (want_rd || want_wr);
    assign load_base = grant_wr ? eff_wr_base : eff_rd_base;

    assign run    = (state == ST_RD_BURST) || (state == ST_WR_BURST);
    assign wr_run = (state == ST_WR_BURST);

    always_ff @(posedge clk) begin
        if (nrst) begin
            state      <= ST_IDLE;
            pend_rd    <= 1'b0;
            pend_wr    <= 1'b0;
            last_grant <= REQ_READ;
            rd_base_q  <= '0;
            wr_base_q  <= '0;
            wr_block_q <= '0;
            rd_valid_q <= 1'b0;
            rd_beat_q  <= '0;
        end else begin
            if (rd_take) begin
                pend_rd   <= 1'b1;
                rd_base_q <= i_rd_base;
            end
            if (wr_take) begin
                pend_wr    <= 1'b1;
                wr_base_q  <= i_wr_base;
                wr_block_q <= i_wr_block;
            end

            case (state)
                ST_IDLE: begin
                    // clearing here overrides a same-cycle set, so a directly granted pulse never lingers
                    if (start) begin
                        if (grant_wr) begin
                            state      <= ST_WR_BURST;
                            last_grant <= REQ_WRITE;
                            pend_wr    <= 1'b0;
                        end else begin
                            state      <= ST_RD_BURST;
                            last_grant <= REQ_READ;
                            pend_rd    <= 1'b0;
                        end
                    end
                end
                ST_RD_BURST, ST_WR_BURST: begin
                    if (last_beat) state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase

            rd_valid_q <= (state == ST_RD_BURST) && i_mem_ready;
            rd_beat_q  <= beat;
        end
    end

    burst_sequencer #(
        .ADDR_BITS (ADDR_BITS),
        .BURST_LEN (BURST_LEN)
    ) u_seq (
        .clk        (clk),
        .nrst       (nrst),
        .load       (start),
        .load_base  (load_base),
        .load_block (eff_wr_block),
        .run        (run),
        .wr         (wr_run),
        .mem_ready  (i_mem_ready),
        .beat       (beat),
        .last_beat  (last_beat),
        .mem_addr   (seq_addr),
        .mem_we     (seq_we),
        .mem_wdata  (seq_wdata)
    );

    // outputs are forced quiet while reset is asserted so an aborted burst writes nothing more
    assign o_mem_addr  = nrst ? '0 : seq_addr;
    assign o_mem_we    = nrst ? '0 : seq_we;
    assign o_mem_wdata = nrst ? '0 : seq_wdata;
    assign o_rd_valid  = !nrst && rd_valid_q;
    assign o_rd_beat   = o_rd_valid ? rd_beat_q : 2'd0;
    assign o_rd_data   = o_rd_valid ? i_mem_rdata : 32'h0;
    assign o_rd_done   = !nrst && (state == ST_DONE) && (last_grant == REQ_READ);
    assign o_wr_done   = !nrst && (state == ST_DONE) && (last_grant == REQ_WRITE);
    assign o_busy      = !nrst && (state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized request mix against a transaction model.
module tb_mem_port_arbiter;

    logic         clk = 1'b0;
    logic         nrst;
    logic         rd_req, wr_req, mem_ready;
    logic [7:0]   rd_base, wr_base;
    logic [127:0] wr_block;
    logic [31:0]  rd_data, mem_wdata, mem_rdata;
    logic         rd_valid, rd_done, wr_done, busy;
    logic [1:0]   rd_beat;
    logic [11:0]  mem_addr;
    logic [3:0]   mem_we;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] ram [0:1023];
    logic [31:0] model_mem [0:1023];
    logic        ram_init;
    logic        mon_en = 1'b0;
    logic [33:0] rdq [$];
    logic        doneq [$];

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_BITS(12)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .i_rd_req    (rd_req),
        .i_rd_base   (rd_base),
        .o_rd_data   (rd_data),
        .o_rd_valid  (rd_valid),
        .o_rd_beat   (rd_beat),
        .o_rd_done   (rd_done),
        .i_wr_req    (wr_req),
        .i_wr_base   (wr_base),
        .i_wr_block  (wr_block),
        .o_wr_done   (wr_done),
        .o_mem_addr  (mem_addr),
        .o_mem_we    (mem_we),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
        .i_mem_ready (mem_ready),
        .o_busy      (busy)
    );

    function automatic logic [31:0] pat(input int i);
        return 32'hA5000000 ^ (32'(i) * 32'h00010103);
    endfunction

    // memory with registered 1-cycle read data; a write lands only on an accepted beat
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 1024; i++) ram[i] <= pat(i);
        end else begin
            if (mem_we == 4'hF && mem_ready) ram[mem_addr[11:2]] <= mem_wdata;
            mem_rdata <= ram[mem_addr[11:2]];
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (rd_valid) rdq.push_back({rd_beat, rd_data});
            if (rd_done)  doneq.push_back(1'b0);
            if (wr_done)  doneq.push_back(1'b1);
        end
    end

    logic [85:0] obs;
    assign obs = {mem_addr, mem_we, mem_wdata, rd_valid, rd_valid ? rd_beat : 2'd0,
                  rd_valid ? rd_data : 32'h0, rd_done, wr_done, busy};

    function automatic logic [85:0] ev(input logic [11:0] a, input logic [3:0] we, input logic [31:0] wd,
                                       input logic v, input logic [1:0] b, input logic [31:0] d,
                                       input logic rdn, input logic wdn, input logic bsy);
        return {a, we, wd, v, v ? b : 2'd0, v ? d : 32'h0, rdn, wdn, bsy};
    endfunction

    // expected port picture k cycles after a read pulse, no stalls
    function automatic logic [85:0] read_exp(input logic [7:0] base, input int k);
        logic [11:0] a;
        logic [1:0]  b;
        a = (k >= 1 && k <= 4) ? {base, 2'(k - 1), 2'b00} : 12'h0;
        b = 2'(k - 2);
        return ev(a, 4'h0, 32'h0, k >= 2 && k <= 5, b, model_mem[{base, b}], k == 5, 1'b0, k >= 1 && k <= 5);
    endfunction

    function automatic logic [85:0] write_exp(input logic [7:0] base, input logic [127:0] blk, input int k);
        logic        on;
        logic [31:0] w;
        on = (k >= 1 && k <= 4);
        w  = blk[32*(k-1) +: 32];
        return ev(on ? {base, 2'(k - 1), 2'b00} : 12'h0, on ? 4'hF : 4'h0, on ? w : 32'h0,
                  1'b0, 2'd0, 32'h0, 1'b0, k == 5, k >= 1 && k <= 5);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        nrst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        nrst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        nrst = 1'b1; rd_req = 1'b1; wr_req = 1'b1; rd_base = 8'h55; wr_base = 8'h66; mem_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== 86'h0) begin
                n_err++;
                $display("FAIL reset_state cycle %0d: got %h want 0", k, obs);
            end
            if (k == 2) begin nrst = 1'b0; rd_req = 1'b0; wr_req = 1'b0; end
        end
    endtask

    task automatic test_read();
        do_reset();
        rd_req = 1'b1; rd_base = 8'h12;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== read_exp(8'h12, k)) begin
                n_err++;
                $display("FAIL read_burst cycle %0d: got %h want %h", k, obs, read_exp(8'h12, k));
            end
            rd_req = 1'b0;
        end
    endtask

    task automatic test_write();
        logic [127:0] blk;
        blk = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        do_reset();
        wr_req = 1'b1; wr_base = 8'h3F; wr_block = blk;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== write_exp(8'h3F, blk, k)) begin
                n_err++;
                $display("FAIL write_burst cycle %0d: got %h want %h", k, obs, write_exp(8'h3F, blk, k));
            end
            wr_req = 1'b0;
        end
        for (int i = 0; i < 4; i++) model_mem[{8'h3F, 2'(i)}] = blk[32*i +: 32];
    endtask

    task automatic test_tie();
        logic [127:0] blk;
        logic [85:0]  e;
        blk = {$urandom, $urandom, $urandom, $urandom};
        do_reset();
        rd_req = 1'b1; rd_base = 8'h21; wr_req = 1'b1; wr_base = 8'h40; wr_block = blk;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (k == 6) for (int i = 0; i < 4; i++) model_mem[{8'h40, 2'(i)}] = blk[32*i +: 32];
            e = (k <= 6) ? write_exp(8'h40, blk, k) : read_exp(8'h21, k - 6);
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL tie_order cycle %0d: got %h want %h", k, obs, e);
            end
            rd_req = 1'b0; wr_req = 1'b0;
        end
    endtask

    task automatic test_stall();
        logic [11:0] ea [1:9];
        logic        ev_v [1:9];
        logic [1:0]  eb [1:9];
        logic [85:0] e;
        ea = '{12'h120, 12'h124, 12'h128, 12'h128, 12'h128, 12'h128, 12'h12C, 12'h000, 12'h000};
        ev_v = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        eb = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd2, 2'd3, 2'd0};
        do_reset();
        rd_req = 1'b1; rd_base = 8'h12;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            e = ev(ea[k], 4'h0, 32'h0, ev_v[k], eb[k], model_mem[{8'h12, eb[k]}], k == 8, 1'b0, k <= 8);
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL stall_hold cycle %0d: got %h want %h", k, obs, e);
            end
            rd_req = 1'b0;
            if (k == 3) mem_ready = 1'b0;
            if (k == 6) mem_ready = 1'b1;
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] blk;
        logic [85:0]  e;
        blk = {$urandom, $urandom, $urandom, $urandom};
        do_reset();
        wr_req = 1'b1; wr_base = 8'h2A; wr_block = blk;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            e = (k <= 2) ? write_exp(8'h2A, blk, k) : 86'h0;
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL reset_abort cycle %0d: got %h want %h", k, obs, e);
            end
            wr_req = 1'b0;
            if (k == 2) nrst = 1'b1;
            if (k == 3) nrst = 1'b0;
        end
        model_mem[{8'h2A, 2'd0}] = blk[31:0];
        for (int i = 1; i < 4; i++) begin
            n_cmp++;
            if (ram[{8'h2A, 2'(i)}] !== model_mem[{8'h2A, 2'(i)}]) begin
                n_err++;
                $display("FAIL reset_abort_mem word %0d: got %h want %h", i, ram[{8'h2A, 2'(i)}],
                         model_mem[{8'h2A, 2'(i)}]);
            end
        end
        rd_req = 1'b1; rd_base = 8'h2A;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== read_exp(8'h2A, k)) begin
                n_err++;
                $display("FAIL read_after_reset cycle %0d: got %h want %h", k, obs, read_exp(8'h2A, k));
            end
            rd_req = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [85:0] e;
        do_reset();
        rd_req = 1'b1; rd_base = 8'h10;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            e = (k <= 6) ? read_exp(8'h10, k) : read_exp(8'h77, k - 6);
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL queued_read cycle %0d: got %h want %h", k, obs, e);
            end
            rd_req = (k == 1 || k == 2);
            rd_base = (k == 1) ? 8'h77 : 8'h99;
        end
    endtask

    task automatic test_random();
        int          kind, cyc, nexp;
        logic [7:0]  rb, wb;
        logic [127:0] blk;
        logic        lg, first, got;
        logic [33:0] rv;
        do_reset();
        lg = 1'b0;
        mon_en = 1'b1;
        for (int it = 0; it < 30; it++) begin
            kind = $urandom_range(0, 2);
            rb = 8'($urandom_range(0, 7));
            wb = 8'($urandom_range(0, 7));
            blk = {$urandom, $urandom, $urandom, $urandom};
            nexp = (kind == 2) ? 2 : 1;
            @(negedge clk);
            rd_req = (kind != 1); wr_req = (kind != 0);
            rd_base = rb; wr_base = wb; wr_block = blk;
            mem_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            rd_req = 1'b0; wr_req = 1'b0;
            cyc = 0;
            #1;
            while (doneq.size() < nexp && cyc < 300) begin
                mem_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                #1;
                cyc++;
            end
            if (doneq.size() < nexp) begin
                n_cmp++; n_err++;
                $display("FAIL rand_timeout op %0d: got %0d dones want %0d", it, doneq.size(), nexp);
                doneq.delete(); rdq.delete();
                continue;
            end
            first = (kind == 2) ? (lg == 1'b0) : (kind == 1);
            for (int j = 0; j < nexp; j++) begin
                logic op;
                op = (j == 0) ? first : ~first;
                got = doneq.pop_front();
                n_cmp++;
                if (got !== op) begin
                    n_err++;
                    $display("FAIL rand_order op %0d: got %0d want %0d", it, got, op);
                end
                if (op) begin
                    for (int i = 0; i < 4; i++) model_mem[{wb, 2'(i)}] = blk[32*i +: 32];
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        rv = (rdq.size() > 0) ? rdq.pop_front() : 34'h3_FFFF_FFFF;
                        n_cmp++;
                        if (rv !== {2'(i), model_mem[{rb, 2'(i)}]}) begin
                            n_err++;
                            $display("FAIL rand_read op %0d beat %0d: got %h want %h", it, i, rv,
                                     {2'(i), model_mem[{rb, 2'(i)}]});
                        end
                    end
                end
                lg = op;
            end
        end
        mon_en = 1'b0;
        n_cmp++;
        if (rdq.size() != 0 || doneq.size() != 0) begin
            n_err++;
            $display("FAIL rand_leftover: got %0d beats %0d dones want 0", rdq.size(), doneq.size());
        end
        for (int i = 0; i < 32; i++) begin
            n_cmp++;
            if (ram[i] !== model_mem[i]) begin
                n_err++;
                $display("FAIL rand_mem word %0d: got %h want %h", i, ram[i], model_mem[i]);
            end
        end
    endtask

    initial begin
        nrst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; mem_ready = 1'b1;
        rd_base = 8'h0; wr_base = 8'h0; wr_block = 128'h0;
        ram_init = 1'b1;
        for (int i = 0; i < 1024; i++) model_mem[i] = pat(i);
        @(negedge clk);
        ram_init = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_tie();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 12: byte-address width of the main-memory port.
REQ-002 SHALL have parameter BURST_LEN, default 4: words per cache block; fixed, not overridden.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port `clk`: input, width 1, the single clock.
REQ-005 Port `nrst`: input, width 1, synchronous active-high reset.
REQ-006 Refill request ports:
- `i_rd_req`: input, width 1, single-cycle refill start pulse.
- `i_rd_base`: input, width ADDR_BITS-4, block base address.
REQ-007 Refill response ports:
- `o_rd_data`: output, width 32, returned word.
- `o_rd_valid`: output, width 1, o_rd_data valid.
- `o_rd_beat`: output, width 2, word index of o_rd_data.
- `o_rd_done`: output, width 1, refill complete pulse.
REQ-008 Evict request ports:
- `i_wr_req`: input, width 1, evict start pulse.
- `i_wr_base`: input, width ADDR_BITS-4, block base.
- `i_wr_block`: input, width 128, block data; word k = bits [32k+31:32k].
REQ-009 Port `o_wr_done`: output, width 1, evict complete pulse.
REQ-010 Memory-side ports:
- `o_mem_addr`: output, width ADDR_BITS.
- `o_mem_we`: output, width 4.
- `o_mem_wdata`: output, width 32.
- `i_mem_rdata`: input, width 32, registered read data with 1-cycle latency.
- `i_mem_ready`: input, width 1, beat accepted.
REQ-011 Port `o_busy`: output, width 1, burst in progress.

Function
REQ-012 SHALL set a per-requester pending flag on its request pulse; the base address (and, for evicts, the block) is latched in the same cycle.
REQ-013 SHALL ignore a request pulse while that requester's flag is already pending; a pulse during that requester's own active burst sets a new pending flag.
REQ-014 States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE -> RD_BURST or WR_BURST when any flag is pending.
- Either burst -> DONE after beat 3 is accepted.
- DONE -> IDLE unconditionally.
REQ-015 Arbitration in IDLE:
- Single pending flag: grant it.
- Both pending: grant the requester not granted last (round-robin).
- last_grant resets to READ, so the first tie goes to evict.
REQ-016 The granted pending flag SHALL clear in the cycle the burst state is entered.
REQ-017 In a burst, o_mem_addr = {latched_base, beat[1:0], 2'b00}.
REQ-018 The beat counter SHALL increment only in cycles with i_mem_ready=1; when i_mem_ready=0, address, we and wdata hold.
REQ-019 RD_BURST:
- o_mem_we=0.
- o_rd_valid=1 the cycle after each accepted beat.
- o_rd_data=i_mem_rdata and o_rd_beat = that beat's index.
REQ-020 WR_BURST: o_mem_we=4'hF and o_mem_wdata = latched block word[beat]; all four bytes are written.
REQ-021 In DONE, SHALL pulse o_rd_done or o_wr_done for one cycle.
- For a read, o_rd_done coincides with o_rd_valid for beat 3.
REQ-022 Latency:
- Request pulse in cycle 0 with i_mem_ready held 1: beat addresses cycles 1-4, done cycle 5.
- Next grant at the earliest in cycle 7.
REQ-023 Outside bursts, o_mem_addr=0, o_mem_we=0 and o_mem_wdata=0.
REQ-024 o_busy=1 in RD_BURST, WR_BURST and DONE.
REQ-025 Beat counter wraps 3->0 only on the transition to DONE; it SHALL never exceed 3.

Reset
REQ-026 When nrst=1 at a clock edge, SHALL go to IDLE, clear both pending flags, beat=0 and last_grant=READ.
REQ-027 During and after reset, all outputs SHALL be 0.
REQ-028 Reset mid-burst SHALL abort the burst with no done pulse and no further memory writes.

Structure
REQ-029 A shared package SHALL hold:
- State encoding.
- BURST_LEN.
- Requester ID constants READ/WRITE.
REQ-030 Sub-module burst_sequencer SHALL own the beat counter, address generation and stall hold; arbitration and pending flags stay in the top.

Verification
REQ-031 Read pulse, base 0x12, ready=1:
- Addresses 0x120, 0x124, 0x128, 0x12C in cycles 1-4.
- o_rd_valid in cycles 2-5 with beats 0-3.
- o_rd_done in cycle 5.
REQ-032 Write pulse, base 0x3F, block 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA:
- we=F, addresses 0x3F0-0x3FC.
- wdata AAAAAAAA..DDDDDDDD.
- o_wr_done in cycle 5.
REQ-033 Read and write pulses in the same cycle: write burst first, then read burst begins in cycle 7.
REQ-034 i_mem_ready=0 for 3 cycles during beat 2: addr 0x128 held, no valid or done early, total done at cycle 8.
REQ-035 nrst=1 during beat 1 of a write:
- we=0 from the next cycle, no o_wr_done.
- Pending flags cleared.
- A new read afterwards completes normally.
REQ-036 Read pulse during an active read burst: second burst is queued and executed after IDLE; a duplicate pulse while pending is ignored.
